// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the two-client RAM port controller: client ids,
// tag-stage field widths and the legal read-latency check.
package ram_ctrl_pkg;

  localparam int CLIENTS = 2;
  localparam int CL0     = 0;
  localparam int CL1     = 1;

  localparam int TAG_VLD_W = 1;
  localparam int TAG_ID_W  = 1;
  localparam int TAG_BYP_W = 1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_latency_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, last winner is
// registered and favours client 0 out of reset.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id,
  output logic       gnt_any
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_id  = gnt[CL1];
  assign gnt_any = |gnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      last <= 1'b1;
    else if (gnt_any)
      last <= gnt_id;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates a simple dual-port RAM's write and read ports between two
// clients and routes read responses back through a latency-matched tag pipe.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              wr_valid,
  output logic [1:0]              wr_ready,
  input  logic [2*ADDR_WIDTH-1:0] wr_addr,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  input  logic [1:0]              rd_valid,
  output logic [1:0]              rd_ready,
  input  logic [2*ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic                    ram_re,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $error("ram_port_arbiter: RD_LATENCY must be 1 or 2");
  end

  localparam int LAST = RD_LATENCY - 1;

  logic wr_id, wr_any, rd_id, rd_any;

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_valid),
    .gnt     (wr_ready),
    .gnt_id  (wr_id),
    .gnt_any (wr_any)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_valid),
    .gnt     (rd_ready),
    .gnt_id  (rd_id),
    .gnt_any (rd_any)
  );

  assign ram_we    = wr_any;
  assign ram_waddr = wr_id ? wr_addr[ADDR_WIDTH +: ADDR_WIDTH] : wr_addr[0 +: ADDR_WIDTH];
  assign ram_wdata = wr_id ? wr_data[DATA_WIDTH +: DATA_WIDTH] : wr_data[0 +: DATA_WIDTH];
  assign ram_re    = rd_any;
  assign ram_raddr = rd_id ? rd_addr[ADDR_WIDTH +: ADDR_WIDTH] : rd_addr[0 +: ADDR_WIDTH];

  // The RAM returns pre-write data on a same-address collision, so capture the write.
  logic collide;
  assign collide = wr_any & rd_any & (ram_raddr == ram_waddr);

  logic                  vld_p  [RD_LATENCY];
  logic                  id_p   [RD_LATENCY];
  logic                  byp_p  [RD_LATENCY];
  logic [DATA_WIDTH-1:0] bdat_p [RD_LATENCY];

  // Stage p0..pLAST: tag shifts every cycle to stay aligned with ram_rdata
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_any;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    id_p[0]   <= rd_id;
    byp_p[0]  <= collide;
    bdat_p[0] <= ram_wdata;
    for (int i = 1; i < RD_LATENCY; i++) begin
      id_p[i]   <= id_p[i-1];
      byp_p[i]  <= byp_p[i-1];
      bdat_p[i] <= bdat_p[i-1];
    end
  end

  // Response stage: route to issuing client, hold data between responses
  logic                  rsp_fire;
  logic [DATA_WIDTH-1:0] rsp_mux;
  logic [DATA_WIDTH-1:0] rsp_hold;

  assign rsp_fire = rst_n & vld_p[LAST];
  assign rsp_mux  = byp_p[LAST] ? bdat_p[LAST] : ram_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n)
      rsp_hold <= '0;
    else if (rsp_fire)
      rsp_hold <= rsp_mux;
  end

  assign rsp_data  = rsp_fire ? rsp_mux : rsp_hold;
  assign rsp_valid = {rsp_fire & id_p[LAST], rsp_fire & ~id_p[LAST]};

endmodule
